// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions: block geometry, counter width, consumer FSM states
// and the "expand 32-byte k" constants used by the generator top.
package chacha20_pkg;

  localparam int CHACHA_WORDS = 16;
  localparam int CTR_W        = 32;

  // Word 0 in the low lane: CHACHA_CONST[0] = 0x61707865.
  localparam logic [3:0][31:0] CHACHA_CONST = {
    32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_STREAM,
    ST_HALT
  } state_e;

endpackage

// File: rtl/chacha20_xor_stream_if.sv
// Config, data stream and keystream handshake of the ChaCha20 XOR stage.
// The slave modport is the XOR stage; master is its environment.
interface chacha20_xor_stream_if #(
  parameter int CTR_W = 32
);
  logic             cfg_load;
  logic [CTR_W-1:0] cfg_counter;
  logic             busy;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             ks_start;
  logic [CTR_W-1:0] ks_counter;
  logic [511:0]     ks_block;
  logic             ks_done;
  logic             ctr_err;

  modport slave (
    input  cfg_load, cfg_counter, in_data, in_valid, in_last, out_ready, ks_block, ks_done,
    output busy, in_ready, out_data, out_valid, out_last, ks_start, ks_counter, ctr_err
  );

  modport master (
    output cfg_load, cfg_counter, in_data, in_valid, in_last, out_ready, ks_block, ks_done,
    input  busy, in_ready, out_data, out_valid, out_last, ks_start, ks_counter, ctr_err
  );
endinterface

// File: rtl/chacha20_ks_buffer.sv
// Captured keystream block plus the index of the next word to consume.
// load takes priority over advance and always restarts at word 0.
module chacha20_ks_buffer #(
  parameter int NUM_WORDS = 16,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic                    advance,
  input  logic [NUM_WORDS*32-1:0] blk,
  output logic [31:0]             word,
  output logic                    last_word
);
  logic [NUM_WORDS-1:0][31:0] kbuf_q;
  logic [IDX_W-1:0]           idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kbuf_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      kbuf_q <= blk;
      idx_q  <= '0;
    end else if (advance) begin
      idx_q  <= idx_q + 1'b1;
    end
  end

  assign word      = kbuf_q[idx_q];
  assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));
endmodule

// File: rtl/chacha20_xor_stream.sv
// ChaCha20 keystream consumer: requests one block per 16 words, XORs it into a
// 32-bit valid/ready stream and advances the block counter without wrapping.
module chacha20_xor_stream #(
  parameter int NUM_WORDS = 16,
  parameter int CTR_W     = 32
) (
  input logic                  clk,
  input logic                  reset_n,
  chacha20_xor_stream_if.slave bus
);
  import chacha20_pkg::*;

  state_e           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [31:0]      ks_word, out_data_q;
  logic             out_valid_q, out_last_q;
  logic             in_ready_w, accept, buf_load, last_word;

  assign in_ready_w = (state_q == ST_STREAM) && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w;
  assign buf_load   = (state_q == ST_WAIT) && bus.ks_done;

  chacha20_ks_buffer #(.NUM_WORDS(NUM_WORDS)) u_ks_buffer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (buf_load),
    .advance   (accept),
    .blk       (bus.ks_block),
    .word      (ks_word),
    .last_word (last_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      // HALT restarts exactly like IDLE; the error flag is the HALT state itself.
      ST_IDLE, ST_HALT: if (bus.cfg_load) begin
        ctr_d   = bus.cfg_counter;
        state_d = ST_REQ;
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: if (bus.ks_done) state_d = ST_STREAM;
      ST_STREAM: if (accept) begin
        if (bus.in_last) begin
          state_d = ST_IDLE;
        end else if (last_word) begin
          if (ctr_q == '1) begin
            state_d = ST_HALT;
          end else begin
            ctr_d   = ctr_q + 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register drains on its own, independent of the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_data_q  <= bus.in_data ^ ks_word;
      out_last_q  <= bus.in_last;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ks_start   = (state_q == ST_REQ);
  assign bus.ks_counter = ctr_q;
  assign bus.ctr_err    = (state_q == ST_HALT);
  assign bus.busy       = (state_q != ST_IDLE) || out_valid_q;
endmodule

// File: tb/tb_chacha20_xor_stream.sv
// Directed/random bench for chacha20_xor_stream with a stub or full ChaCha20
// generator and a message-level reference model of the expected output stream.
module tb_chacha20_xor_stream;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  chacha20_xor_stream_if #(.CTR_W(32)) bus ();
  chacha20_xor_stream #(.NUM_WORDS(16), .CTR_W(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          gen_real = 1'b0;
  int          ks_starts = 0;
  logic [31:0] ks_ctrs[$];
  logic [32:0] got[$];
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
    a += b; d ^= a; d = rotl(d, 16);
    c += d; b ^= c; b = rotl(b, 12);
    a += b; d ^= a; d = rotl(d, 8);
    c += d; b ^= c; b = rotl(b, 7);
    return {a, b, c, d};
  endfunction

  // RFC 7539 block function, key 00..1f, nonce 000000090000004a00000000.
  function automatic logic [511:0] chacha_block(input logic [31:0] ctr);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    s[12] = ctr; s[13] = 32'h09000000; s[14] = 32'h4a000000; s[15] = 32'h0;
    x = s;
    for (int r2 = 0; r2 < 10; r2++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = x[i] + s[i];
    return r;
  endfunction

  function automatic logic [511:0] gen_block(input logic [31:0] ctr);
    logic [511:0] r;
    if (gen_real) return chacha_block(ctr);
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = {ctr[15:0], 16'(i)};
    return r;
  endfunction

  function automatic logic [31:0] ks_word(input logic [31:0] ctr, input int i);
    logic [511:0] b;
    b = gen_block(ctr);
    return b[i*32 +: 32];
  endfunction

  // Message model: word j uses block counter c + j/16; the stream halts after
  // word 15 of block 2^32-1 unless that word carries in_last.
  task automatic model_msg(input logic [31:0] c, input logic [31:0] w[$], input bit has_last,
                           output int n_acc);
    logic [31:0] blk;
    bit          lst;
    n_acc = 0;
    for (int j = 0; j < w.size(); j++) begin
      blk = c + 32'(j / 16);
      lst = has_last && (j == w.size() - 1);
      exp_q.push_back({lst, w[j] ^ ks_word(blk, j % 16)});
      n_acc++;
      if (!lst && (j % 16 == 15) && (blk == 32'hFFFF_FFFF)) break;
    end
  endtask

  // Stub generator: ks_done with the block 3 cycles after ks_start.
  initial begin
    logic [31:0] c;
    bus.ks_done  = 1'b0;
    bus.ks_block = '0;
    forever begin
      @(negedge clk);
      if (bus.ks_start) begin
        c = bus.ks_counter;
        ks_starts++;
        ks_ctrs.push_back(c);
        repeat (3) @(posedge clk);
        #1;
        bus.ks_block = gen_block(c);
        bus.ks_done  = 1'b1;
        @(posedge clk);
        #1;
        bus.ks_done  = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && bus.out_valid && bus.out_ready) got.push_back({bus.out_last, bus.out_data});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] c);
    bus.cfg_counter = c;
    bus.cfg_load    = 1'b1;
    cyc();
    bus.cfg_load    = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input bit last, input int budget, output bit ok);
    ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    for (int t = 0; t < budget && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_msg(input logic [31:0] c, input logic [31:0] w[$], input bit has_last,
                         output int n_acc);
    bit ok;
    n_acc = 0;
    cfg(c);
    for (int j = 0; j < w.size(); j++) begin
      push_word(w[j], has_last && (j == w.size() - 1), 40, ok);
      if (!ok) break;
      n_acc++;
    end
  endtask

  task automatic compare_stream(input string tag);
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] snap;
    int          acc, macc, s0;
    bit          ok, fell;

    bus.cfg_load = 0; bus.cfg_counter = '0; bus.in_data = '0; bus.in_valid = 0;
    bus.in_last = 0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) cyc();
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_ks_start", bus.ks_start, 0);
    chk("rst_ks_counter", bus.ks_counter, 0);
    chk("rst_ctr_err", bus.ctr_err, 0);
    reset_n = 1'b1;
    cyc();

    // Stub keystream, 20 zero words across two blocks
    s0 = ks_starts; ks_ctrs.delete(); w.delete();
    for (int i = 0; i < 20; i++) w.push_back(32'h0);
    model_msg(1, w, 1, macc);
    run_msg(1, w, 1, acc);
    chk("stub_accepted", acc, 20);
    bus.out_ready = 1'b1; repeat (4) cyc();
    chk("stub_w0", got[0], {1'b0, 32'h00010000});
    chk("stub_w15", got[15], {1'b0, 32'h0001000F});
    chk("stub_w16", got[16], {1'b0, 32'h00020000});
    chk("stub_w19_last", got[19], {1'b1, 32'h00020003});
    chk("stub_starts", ks_starts - s0, 2);
    chk("stub_ctr0", ks_ctrs[0], 1);
    chk("stub_ctr1", ks_ctrs[1], 2);
    compare_stream("stub");

    // Backpressure: stall 5 cycles mid-block
    w.delete();
    for (int i = 0; i < 10; i++) w.push_back($urandom);
    model_msg(5, w, 1, macc);
    cfg(5);
    for (int i = 0; i < 4; i++) begin
      push_word(w[i], 0, 40, ok);
      chk("bp_push", ok, 1);
    end
    bus.out_ready = 1'b0;
    bus.in_data = w[4]; bus.in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      snap = bus.out_data;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_data", snap, exp_q[3][31:0]);
      cyc();
    end
    bus.out_ready = 1'b1;
    for (int i = 4; i < 10; i++) begin
      push_word(w[i], i == 9, 40, ok);
      chk("bp_push2", ok, 1);
    end
    compare_stream("bp");

    // Counter exhaustion at 0xFFFFFFFF
    s0 = ks_starts; ks_ctrs.delete(); w.delete();
    for (int i = 0; i < 17; i++) w.push_back($urandom);
    model_msg(32'hFFFF_FFFF, w, 0, macc);
    run_msg(32'hFFFF_FFFF, w, 0, acc);
    chk("halt_accepted", acc, macc);
    chk("halt_accepted16", acc, 16);
    chk("halt_ctr_err", bus.ctr_err, 1);
    chk("halt_in_ready", bus.in_ready, 0);
    chk("halt_starts", ks_starts - s0, 1);
    compare_stream("halt");
    cfg(0);
    chk("halt_clr_err", bus.ctr_err, 0);
    chk("halt_restart", bus.ks_start, 1);
    chk("halt_restart_ctr", bus.ks_counter, 0);
    snap = $urandom;
    exp_q.push_back({1'b1, snap ^ ks_word(0, 0)});
    push_word(snap, 1, 40, ok);
    chk("halt_push", ok, 1);
    compare_stream("restart");

    // Real ChaCha20 keystream and XOR round trip
    gen_real = 1'b1;
    w.delete(); w.push_back(0); w.push_back(0);
    model_msg(1, w, 1, macc);
    run_msg(1, w, 1, acc);
    bus.out_ready = 1'b1; repeat (4) cyc();
    chk("rfc_word0", got[0][31:0], 32'he4e7f110);
    w.delete(); w.push_back(got[0][31:0]); w.push_back(got[1][31:0]);
    compare_stream("rfc");
    run_msg(1, w, 1, acc);
    bus.out_ready = 1'b1; repeat (4) cyc();
    chk("rfc_rt0", got[0], {1'b0, 32'h0});
    chk("rfc_rt1", got[1], {1'b1, 32'h0});
    got.delete();
    gen_real = 1'b0;

    // Asynchronous reset while waiting for the generator
    s0 = ks_starts;
    cfg(9);
    cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_ks_start", bus.ks_start, 0);
    chk("arst_ks_counter", bus.ks_counter, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cyc();
      chk("arst_late_busy", bus.busy, 0);
      chk("arst_late_out_valid", bus.out_valid, 0);
    end
    chk("arst_starts", ks_starts - s0, 1);
    chk("arst_no_out", got.size(), 0);

    // Early in_last, then a fresh message restarting at buffer word 0
    w.delete();
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    model_msg(3, w, 1, macc);
    run_msg(3, w, 1, acc);
    fell = 1'b0;
    for (int t = 0; t < 5 && !fell; t++) begin
      if (!bus.busy) fell = 1'b1;
      else cyc();
    end
    chk("early_busy_fall", fell, 1);
    compare_stream("early");
    ks_ctrs.delete(); w.delete();
    for (int i = 0; i < 2; i++) w.push_back($urandom);
    model_msg(7, w, 1, macc);
    run_msg(7, w, 1, acc);
    chk("next_ctr", ks_ctrs[0], 7);
    compare_stream("next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
